// File: rtl/clk_phase_reset_gen.sv
// -----------------------------------------------------------------------------
// clk_phase_reset_gen
//
// Clock/reset front end of the 8085 system. From the x1 oscillator it derives
// the two-phase non-overlapping phi1/phi2 pair, the system clock clk_out and a
// per-period strobe. It synchronises the release of resetn_in, stretches the
// system reset over a number of full clock periods, and provides a halt
// handshake that parks both phases low on a machine-period boundary.
//
// Parameters
//   PHASE_LEN    x1 cycles each of phi1 / phi2 is high (>= 1)
//   GAP          x1 dead cycles after each phase (>= 1)
//   SYNC_STAGES  depth of the reset-release synchroniser (>= 2)
//   RST_STRETCH  full periods reset_out stays high after synced release (>= 1)
//
// Ports
//   x1          in   oscillator clock, every flop uses its rising edge
//   resetn_in   in   asynchronous active-low reset
//   halt_req    in   synchronous to x1, request to park the clocks
//   halt_ack    out  high while the clocks are parked
//   phi1        out  phase-1 clock
//   phi2        out  phase-2 clock
//   clk_out     out  system clock, high for the first half of each period
//   reset_out   out  active-high system reset
//   period_end  out  one-cycle pulse on the last x1 cycle of a running period
// -----------------------------------------------------------------------------
module clk_phase_reset_gen #(
  parameter int PHASE_LEN   = 1,
  parameter int GAP         = 1,
  parameter int SYNC_STAGES = 2,
  parameter int RST_STRETCH = 8
) (
  input  logic x1,
  input  logic resetn_in,
  input  logic halt_req,
  output logic halt_ack,
  output logic phi1,
  output logic phi2,
  output logic clk_out,
  output logic reset_out,
  output logic period_end
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int PERIOD = 2 * (PHASE_LEN + GAP);
  localparam int CW     = $clog2(PERIOD);
  localparam int SW     = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;

  // Phase-counter landmarks, pre-sized so every compare is width-matched.
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
  localparam logic [CW-1:0] P1_LAST   = CW'(PHASE_LEN - 1);
  localparam logic [CW-1:0] P2_FIRST  = CW'(PHASE_LEN + GAP);
  localparam logic [CW-1:0] P2_LAST   = CW'(2 * PHASE_LEN + GAP - 1);
  localparam logic [CW-1:0] HALF_END  = CW'(PHASE_LEN + GAP);

  localparam logic [SW-1:0] STR_ZERO  = {SW{1'b0}};
  localparam logic [SW-1:0] STR_ONE   = SW'(1);
  localparam logic [SW-1:0] STR_LAST  = SW'(RST_STRETCH - 1);

  localparam logic [SYNC_STAGES-1:0] SYNC_ZERO = {SYNC_STAGES{1'b0}};

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (PHASE_LEN < 1) begin : g_bad_phase_len
    $error("clk_phase_reset_gen: PHASE_LEN must be >= 1 (got %0d)", PHASE_LEN);
  end
  if (GAP < 1) begin : g_bad_gap
    $error("clk_phase_reset_gen: GAP must be >= 1 (got %0d)", GAP);
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("clk_phase_reset_gen: SYNC_STAGES must be >= 2 (got %0d)", SYNC_STAGES);
  end
  if (RST_STRETCH < 1) begin : g_bad_rst_stretch
    $error("clk_phase_reset_gen: RST_STRETCH must be >= 1 (got %0d)", RST_STRETCH);
  end

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RUN     = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Waveform decode of one phase-counter value: {phi1, phi2, clk_out, period_end}.
  function automatic logic [3:0] phase_decode(input logic [CW-1:0] c);
    logic p1;
    logic p2;
    logic ck;
    logic pe;
    p1 = (c <= P1_LAST);
    p2 = (c >= P2_FIRST) && (c <= P2_LAST);
    ck = (c < HALF_END);
    pe = (c == CNT_LAST);
    return {p1, p2, ck, pe};
  endfunction

  // The phase decode is only driven onto the pins while the clocks are running.
  function automatic logic clocks_running(input state_t s);
    return (s == ST_STRETCH) || (s == ST_RUN);
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                 state_r;
  logic [CW-1:0]          cnt_r;
  logic [SW-1:0]          str_cnt_r;
  logic [SYNC_STAGES-1:0] sync_r;

  logic phi1_r;
  logic phi2_r;
  logic clk_out_r;
  logic period_end_r;
  logic reset_out_r;
  logic halt_ack_r;

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  state_t        state_s;
  logic [CW-1:0] cnt_s;
  logic [SW-1:0] str_cnt_s;
  logic          cnt_wrap_s;
  logic [3:0]    dec_s;
  logic [3:0]    phase_s;
  logic          reset_out_s;
  logic          halt_ack_s;

  // Next state, next phase count and the output values that go with them.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    str_cnt_s   = str_cnt_r;
    cnt_wrap_s  = (cnt_r == CNT_LAST);

    case (state_r)
      ST_RESET: begin
        // Leave reset on the edge after the last synchroniser stage reads 1.
        cnt_s     = CNT_ZERO;
        str_cnt_s = STR_ZERO;
        if (sync_r[SYNC_STAGES-1]) begin
          state_s = ST_STRETCH;
        end else begin
          state_s = ST_RESET;
        end
      end

      ST_STRETCH: begin
        // Count completed periods; the wrap that ends the last one enters RUN,
        // so the first running period starts with phi1 high and reset low.
        if (cnt_wrap_s) begin
          cnt_s = CNT_ZERO;
          if (str_cnt_r == STR_LAST) begin
            state_s   = ST_RUN;
            str_cnt_s = STR_ZERO;
          end else begin
            state_s   = ST_STRETCH;
            str_cnt_s = str_cnt_r + STR_ONE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_RUN: begin
        // halt_req only counts on the last cycle of a period, so a park
        // never truncates a machine period.
        if (cnt_wrap_s) begin
          cnt_s = CNT_ZERO;
          if (halt_req) begin
            state_s = ST_HALTED;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_HALTED: begin
        // Resume at the start of a fresh period as soon as the request drops.
        cnt_s = CNT_ZERO;
        if (!halt_req) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_HALTED;
        end
      end

      default: begin
        state_s   = ST_RESET;
        cnt_s     = CNT_ZERO;
        str_cnt_s = STR_ZERO;
      end
    endcase

    // Outputs are computed from the next count/state so the registered pins
    // line up with cnt_r with no extra cycle of latency.
    dec_s = phase_decode(cnt_s);
    if (clocks_running(state_s)) begin
      phase_s = dec_s;
    end else begin
      phase_s = 4'b0000;
    end

    reset_out_s = (state_s == ST_RESET) || (state_s == ST_STRETCH);
    halt_ack_s  = (state_s == ST_HALTED);
  end

  // State, counters, reset synchroniser and glitch-free output flops.
  always_ff @(posedge x1 or negedge resetn_in) begin
    if (!resetn_in) begin
      state_r      <= ST_RESET;
      cnt_r        <= CNT_ZERO;
      str_cnt_r    <= STR_ZERO;
      sync_r       <= SYNC_ZERO;
      phi1_r       <= 1'b0;
      phi2_r       <= 1'b0;
      clk_out_r    <= 1'b0;
      period_end_r <= 1'b0;
      reset_out_r  <= 1'b1;
      halt_ack_r   <= 1'b0;
    end else begin
      // Ones enter the chain only after release; any reset pulse, however
      // short, clears it and forces a complete re-sync and stretch.
      sync_r       <= {sync_r[SYNC_STAGES-2:0], 1'b1};
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      str_cnt_r    <= str_cnt_s;
      phi1_r       <= phase_s[3];
      phi2_r       <= phase_s[2];
      clk_out_r    <= phase_s[1];
      period_end_r <= phase_s[0];
      reset_out_r  <= reset_out_s;
      halt_ack_r   <= halt_ack_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Output pins come straight from flops
  // ---------------------------------------------------------------------------
  assign phi1       = phi1_r;
  assign phi2       = phi2_r;
  assign clk_out    = clk_out_r;
  assign period_end = period_end_r;
  assign reset_out  = reset_out_r;
  assign halt_ack   = halt_ack_r;

endmodule

// File: tb/tb_clk_phase_reset_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_phase_reset_gen
//
// Drives two instances (default parameters, and PHASE_LEN=2/GAP=1) from a
// shared x1, resetn_in and halt_req. A timeline model tracks, per instance,
// how many running x1 cycles have elapsed since leaving reset; outputs are
// derived from that count with plain modulo arithmetic and compared every
// cycle. Directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_clk_phase_reset_gen;

  localparam int SYNC = 2;
  localparam int RS   = 8;

  logic x1        = 1'b0;
  logic resetn_in = 1'b0;
  logic halt_req  = 1'b0;

  logic a_ack, a_phi1, a_phi2, a_clk, a_rst, a_pe;
  logic b_ack, b_phi1, b_phi2, b_clk, b_rst, b_pe;

  int total = 0;
  int bad   = 0;

  always #5 x1 = ~x1;

  clk_phase_reset_gen u_dut_a (
    .x1(x1), .resetn_in(resetn_in), .halt_req(halt_req),
    .halt_ack(a_ack), .phi1(a_phi1), .phi2(a_phi2), .clk_out(a_clk),
    .reset_out(a_rst), .period_end(a_pe)
  );

  clk_phase_reset_gen #(.PHASE_LEN(2), .GAP(1), .SYNC_STAGES(2), .RST_STRETCH(8)) u_dut_b (
    .x1(x1), .resetn_in(resetn_in), .halt_req(halt_req),
    .halt_ack(b_ack), .phi1(b_phi1), .phi2(b_phi2), .clk_out(b_clk),
    .reset_out(b_rst), .period_end(b_pe)
  );

  // ---------------------------------------------------------------------------
  // Timeline model
  // ---------------------------------------------------------------------------
  function automatic int pl_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int per_of(input int k);
    return 2 * (pl_of(k) + 1);
  endfunction

  int m_rel [2] = '{0, 0};   // edges seen since release while not yet running
  bit m_act [2] = '{1'b0, 1'b0};
  bit m_hlt [2] = '{1'b0, 1'b0};
  int m_t   [2] = '{0, 0};   // running cycles since leaving reset

  always @(posedge x1 or negedge resetn_in) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetn_in) begin
        m_rel[k] = 0; m_act[k] = 1'b0; m_hlt[k] = 1'b0; m_t[k] = 0;
      end else if (!m_act[k]) begin
        m_rel[k] = m_rel[k] + 1;
        if (m_rel[k] == SYNC + 1) begin
          m_act[k] = 1'b1;
          m_t[k]   = 0;
        end
      end else if (m_hlt[k]) begin
        if (!halt_req) begin
          m_hlt[k] = 1'b0;
          m_t[k]   = m_t[k] + 1;
        end
      end else if ((m_t[k] % per_of(k)) == per_of(k) - 1 &&
                   m_t[k] >= per_of(k) * RS && halt_req) begin
        m_hlt[k] = 1'b1;
      end else begin
        m_t[k] = m_t[k] + 1;
      end
    end
  end

  // Expected {phi1, phi2, clk_out, period_end, reset_out, halt_ack}.
  function automatic int model_vec(input int k);
    int p, pl, pos, v;
    p  = per_of(k);
    pl = pl_of(k);
    if (!m_act[k]) return 6'b000010;
    if (m_hlt[k])  return 6'b000001;
    pos = m_t[k] % p;
    v = 0;
    if (pos < pl)                          v = v | 32;
    if (pos >= pl + 1 && pos < 2 * pl + 1) v = v | 16;
    if (pos < pl + 1)                      v = v | 8;
    if (pos == p - 1)                      v = v | 4;
    if (m_t[k] < p * RS)                   v = v | 2;
    return v;
  endfunction

  function automatic int dut_vec(input int k);
    logic [5:0] v;
    if (k == 0) v = {a_phi1, a_phi2, a_clk, a_pe, a_rst, a_ack};
    else        v = {b_phi1, b_phi2, b_clk, b_pe, b_rst, b_ack};
    return int'(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input int got, input int exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
    end
  endtask

  // One x1 cycle; outputs compared against the model 1ns after the edge.
  task automatic tick();
    @(posedge x1);
    #1;
    check("model_a", dut_vec(0), model_vec(0));
    check("model_b", dut_vec(1), model_vec(1));
  endtask

  // Edges (counted from release) of first phi1 high and of reset_out falling.
  task automatic measure(output int fa, output int ra, output int fb, output int rb);
    fa = 0; ra = 0; fb = 0; rb = 0;
    for (int e = 1; e <= 60; e++) begin
      tick();
      if (fa == 0 && a_phi1) fa = e;
      if (ra == 0 && !a_rst) ra = e;
      if (fb == 0 && b_phi1) fb = e;
      if (rb == 0 && !b_rst) rb = e;
    end
  endtask

  // Sync to instance k's period_end, then shift in n cycles of each waveform.
  task automatic capture(input int k, input int n,
                         output int p1, output int p2, output int ck, output int pe);
    bit found;
    int v;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      v = dut_vec(k);
      if (v[2]) found = 1'b1;
    end
    check("align_period_end", int'(found), 1);
    p1 = 0; p2 = 0; ck = 0; pe = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      v = dut_vec(k);
      p1 = (p1 << 1) | v[5];
      p2 = (p2 << 1) | v[4];
      ck = (ck << 1) | v[3];
      pe = (pe << 1) | v[2];
    end
  endtask

  // Leaves instance A just after the edge that loaded cnt=1.
  task automatic align_a_cnt1();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (a_pe) found = 1'b1;
    end
    check("align_a_cnt1", int'(found), 1);
    tick();
    tick();
  endtask

  // Short resetn_in pulse between clock edges, checked while it is low.
  task automatic glitch(input string name);
    resetn_in = 1'b0;
    #2;
    check({name, "_a"}, dut_vec(0), 6'b000010);
    check({name, "_b"}, dut_vec(1), 6'b000010);
    #1;
    resetn_in = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int fa, ra, fb, rb;
    int p1, p2, ck, pe;
    int ovl;
    bit found;

    // Long reset, then release.
    repeat (56) tick();
    check("reset_vec_a", dut_vec(0), 6'b000010);
    check("reset_vec_b", dut_vec(1), 6'b000010);
    resetn_in = 1'b1;
    measure(fa, ra, fb, rb);
    check("first_phi1_a", fa, 3);
    check("rst_fall_a", ra, 35);
    check("first_phi1_b", fb, 3);
    check("rst_fall_b", rb, 51);

    // Free-running waveforms.
    capture(0, 4, p1, p2, ck, pe);
    check("pat_phi1_a", p1, 4'b1000);
    check("pat_phi2_a", p2, 4'b0010);
    check("pat_clk_a",  ck, 4'b1100);
    check("pat_pe_a",   pe, 4'b0001);
    capture(1, 6, p1, p2, ck, pe);
    check("pat_phi1_b", p1, 6'b110000);
    check("pat_phi2_b", p2, 6'b000110);
    check("pat_clk_b",  ck, 6'b111000);
    check("pat_pe_b",   pe, 6'b000001);

    ovl = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (a_phi1 && a_phi2) ovl = ovl + 1;
      if (b_phi1 && b_phi2) ovl = ovl + 1;
    end
    check("phase_overlap", ovl, 0);

    // Halt raised at cnt=1: clocks finish the period, then park.
    align_a_cnt1();
    halt_req = 1'b1;
    tick();
    check("halt_cnt2_phi2", int'(a_phi2), 1);
    tick();
    check("halt_cnt3_pe_ack", int'({a_pe, a_ack}), 2'b10);
    tick();
    check("halt_parked", int'({a_phi1, a_phi2, a_clk, a_ack}), 4'b0001);
    repeat (10) tick();
    check("halt_held", int'({a_phi1, a_ack}), 2'b01);
    halt_req = 1'b0;
    tick();
    check("halt_resume", int'({a_phi1, a_ack}), 2'b10);

    // Halt pulse that does not reach the boundary.
    align_a_cnt1();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    tick();
    check("pulse_no_halt", int'({a_phi1, a_ack}), 2'b10);

    // Glitch while halted; halt_req stays high through the stretch.
    halt_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (a_ack) found = 1'b1;
    end
    check("reach_halted", int'(found), 1);
    glitch("glitch_halted");
    measure(fa, ra, fb, rb);
    check("re1_first_phi1_a", fa, 3);
    check("re1_rst_fall_a", ra, 35);
    check("re1_first_phi1_b", fb, 3);
    check("re1_rst_fall_b", rb, 51);
    halt_req = 1'b0;

    // Glitch mid-run.
    repeat (7) tick();
    glitch("glitch_run");
    measure(fa, ra, fb, rb);
    check("re2_first_phi1_a", fa, 3);
    check("re2_rst_fall_a", ra, 35);
    check("re2_first_phi1_b", fb, 3);
    check("re2_rst_fall_b", rb, 51);
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
